// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for one data-memory client of dmem_arbiter.
// The master drives the request; the slave (arbiter) answers with grant and read data.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req;
  logic [3:0]        we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data_mem between the core LSU (m0) and DMA/debug (m1),
// one access per cycle, with aging so m1 cannot be starved by a busy core.
module dmem_arbiter #(
  parameter  int ADDR_W   = 10,
  parameter  int DATA_W   = 32,
  parameter  int MAX_WAIT = 4,
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_we_o,
  output logic              dmem_re_o,
  output logic [DATA_W-1:0] dmem_in_o,
  input  logic [DATA_W-1:0] dmem_out_i,
  output logic [WAIT_W-1:0] wait_cnt_o
);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic              pend_q, pend_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [3:0]        we_d;
  logic              re_d;

  always_comb begin
    gnt1     = !rst && m1.req && (!m0.req || (wait_q == WAIT_W'(MAX_WAIT)));
    gnt0     = !rst && m0.req && !gnt1;
    addr_d   = addr_q;
    in_d     = in_q;
    we_d     = 4'b0000;
    re_d     = 1'b0;
    if (gnt1) begin
      addr_d = m1.addr;
      in_d   = m1.wdata;
      we_d   = m1.we;
      re_d   = (m1.we == 4'b0000);
    end else if (gnt0) begin
      addr_d = m0.addr;
      in_d   = m0.wdata;
      we_d   = m0.we;
      re_d   = (m0.we == 4'b0000);
    end

    // Aging counter only grows while m1 is actively refused.
    if (m1.req && !gnt1) begin
      wait_d = (wait_q == WAIT_W'(MAX_WAIT)) ? wait_q : wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end

    pend_d   = re_d;
    owner_d  = gnt1;
    rvalid0  = !rst && pend_q && !owner_q;
    rvalid1  = !rst && pend_q && owner_q;
    rdata0_d = rvalid0 ? dmem_out_i : rdata0_q;
    rdata1_d = rvalid1 ? dmem_out_i : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q   <= '0;
      addr_q   <= '0;
      in_q     <= '0;
      pend_q   <= 1'b0;
      owner_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      in_q     <= in_d;
      pend_q   <= pend_d;
      owner_q  <= owner_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Gating with rst keeps every output at zero even before the first reset edge.
  assign m0.gnt      = gnt0;
  assign m1.gnt      = gnt1;
  assign m0.rvalid   = rvalid0;
  assign m1.rvalid   = rvalid1;
  assign m0.rdata    = rst ? '0 : rdata0_d;
  assign m1.rdata    = rst ? '0 : rdata1_d;
  assign dmem_addr_o = rst ? '0 : addr_d;
  assign dmem_in_o   = rst ? '0 : in_d;
  assign dmem_we_o   = we_d;
  assign dmem_re_o   = re_d;
  assign wait_cnt_o  = rst ? '0 : wait_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data_mem, an arbitration
// model and per-port read-data scoreboards.
module tb_dmem_arbiter;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0If ();
  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1If ();

  logic [ADDR_W-1:0] dmemAddr;
  logic [3:0]        dmemWe;
  logic              dmemRe;
  logic [DATA_W-1:0] dmemIn;
  logic [DATA_W-1:0] dmemOut;
  logic [2:0]        waitCnt;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0If),
    .m1          (m1If),
    .dmem_addr_o (dmemAddr),
    .dmem_we_o   (dmemWe),
    .dmem_re_o   (dmemRe),
    .dmem_in_o   (dmemIn),
    .dmem_out_i  (dmemOut),
    .wait_cnt_o  (waitCnt)
  );

  logic [DATA_W-1:0] mem    [0:1023];
  logic [DATA_W-1:0] refMem [0:1023];

  always @(posedge clk) begin
    if (dmemRe) dmemOut <= mem[dmemAddr];
    for (int b = 0; b < 4; b++) begin
      if (dmemWe[b]) mem[dmemAddr][8*b +: 8] = dmemIn[8*b +: 8];
    end
  end

  int checks = 0;
  int fails  = 0;
  int expWait;
  bit expPend0, expPend1;
  logic [DATA_W-1:0] q0 [$];
  logic [DATA_W-1:0] q1 [$];
  logic [DATA_W-1:0] last0, last1;
  logic [ADDR_W-1:0] expAddr;
  logic [DATA_W-1:0] expIn;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit r,
                               input bit req0, input logic [3:0] we0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                               input bit req1, input logic [3:0] we1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    rst        = r;
    m0If.req   = req0;
    m0If.we    = we0;
    m0If.addr  = a0;
    m0If.wdata = d0;
    m1If.req   = req1;
    m1If.we    = we1;
    m1If.addr  = a1;
    m1If.wdata = d1;
  endtask

  // Checks one cycle at the falling edge against the model, then advances the model.
  task automatic runCycle();
    bit w0, w1;
    logic [3:0]        wWe;
    logic [ADDR_W-1:0] wAddr;
    logic [DATA_W-1:0] wData;
    @(negedge clk);
    if (rst) begin
      checkOutput("rst_m0_gnt", m0If.gnt, 0);
      checkOutput("rst_m1_gnt", m1If.gnt, 0);
      checkOutput("rst_m0_rvalid", m0If.rvalid, 0);
      checkOutput("rst_m1_rvalid", m1If.rvalid, 0);
      checkOutput("rst_m0_rdata", m0If.rdata, 0);
      checkOutput("rst_m1_rdata", m1If.rdata, 0);
      checkOutput("rst_dmem_we", dmemWe, 0);
      checkOutput("rst_dmem_re", dmemRe, 0);
      checkOutput("rst_dmem_addr", dmemAddr, 0);
      checkOutput("rst_dmem_in", dmemIn, 0);
      checkOutput("rst_wait_cnt", waitCnt, 0);
      expWait  = 0;
      expPend0 = 0;
      expPend1 = 0;
      q0.delete();
      q1.delete();
      last0    = '0;
      last1    = '0;
      expAddr  = '0;
      expIn    = '0;
    end else begin
      w1 = m1If.req && (!m0If.req || expWait == MAX_WAIT);
      w0 = m0If.req && !w1;
      checkOutput("m0_gnt", m0If.gnt, w0);
      checkOutput("m1_gnt", m1If.gnt, w1);
      checkOutput("gnt_exclusive", m0If.gnt & m1If.gnt, 0);
      checkOutput("wait_cnt", waitCnt, expWait);
      wWe = 4'b0000;
      if (w1) begin
        wWe = m1If.we; wAddr = m1If.addr; wData = m1If.wdata;
      end else if (w0) begin
        wWe = m0If.we; wAddr = m0If.addr; wData = m0If.wdata;
      end
      if (w0 || w1) begin
        expAddr = wAddr;
        expIn   = wData;
      end
      checkOutput("dmem_addr", dmemAddr, expAddr);
      checkOutput("dmem_in", dmemIn, expIn);
      checkOutput("dmem_we", dmemWe, wWe);
      checkOutput("dmem_re", dmemRe, (w0 || w1) && wWe == 4'b0000);

      checkOutput("m0_rvalid", m0If.rvalid, expPend0);
      checkOutput("m1_rvalid", m1If.rvalid, expPend1);
      if (expPend0 && q0.size() > 0) last0 = q0.pop_front();
      if (expPend1 && q1.size() > 0) last1 = q1.pop_front();
      checkOutput("m0_rdata", m0If.rdata, last0);
      checkOutput("m1_rdata", m1If.rdata, last1);

      expPend0 = w0 && wWe == 4'b0000;
      expPend1 = w1 && wWe == 4'b0000;
      if (expPend0) q0.push_back(refMem[wAddr]);
      if (expPend1) q1.push_back(refMem[wAddr]);
      if (w0 || w1) begin
        for (int b = 0; b < 4; b++) begin
          if (wWe[b]) refMem[wAddr][8*b +: 8] = wData[8*b +: 8];
        end
      end
      if (m1If.req && !w1) expWait = (expWait == MAX_WAIT) ? MAX_WAIT : expWait + 1;
      else expWait = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = DATA_W'(i);
      refMem[i] = DATA_W'(i);
    end

    // Reset held two cycles with random requester activity.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1'($urandom), 4'($urandom), 10'($urandom), $urandom,
                       1'($urandom), 4'($urandom), 10'($urandom), $urandom);
      runCycle();
    end

    applyStimulus(0, 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    runCycle();

    // m0 read of addr 5 and its return.
    applyStimulus(0, 1, 4'h0, 10'd5, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    runCycle();
    applyStimulus(0, 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    runCycle();
    checkOutput("t2_m0_rdata_hold", m0If.rdata, 32'h0000_0005);

    // m1 write then read-back of addr 3.
    applyStimulus(0, 0, 4'h0, 10'd0, 32'h0, 1, 4'hF, 10'd3, 32'hDEADBEEF);
    runCycle();
    applyStimulus(0, 0, 4'h0, 10'd0, 32'h0, 1, 4'h0, 10'd3, 32'h0);
    runCycle();
    applyStimulus(0, 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    runCycle();
    checkOutput("t3_m1_rdata_hold", m1If.rdata, 32'hDEADBEEF);

    // Byte-lane write merge on addr 7.
    applyStimulus(0, 1, 4'hF, 10'd7, 32'h11223344, 0, 4'h0, 10'd0, 32'h0);
    runCycle();
    applyStimulus(0, 1, 4'h2, 10'd7, 32'h0000AB00, 0, 4'h0, 10'd0, 32'h0);
    runCycle();
    applyStimulus(0, 1, 4'h0, 10'd7, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    runCycle();
    applyStimulus(0, 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    runCycle();
    checkOutput("t4_m0_rdata_hold", m0If.rdata, 32'h1122AB44);

    // m0 read collides with m1 write; m1 is served once m0 backs off.
    applyStimulus(0, 1, 4'h0, 10'd3, 32'h0, 1, 4'hF, 10'd3, 32'h12345678);
    runCycle();
    applyStimulus(0, 0, 4'h0, 10'd0, 32'h0, 1, 4'hF, 10'd3, 32'h12345678);
    runCycle();
    applyStimulus(0, 1, 4'h0, 10'd3, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    runCycle();
    applyStimulus(0, 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    runCycle();
    checkOutput("collide_m0_rdata", m0If.rdata, 32'h12345678);

    // Both ports saturate the bus with reads; aging must interleave m1.
    applyStimulus(0, 1, 4'h0, 10'd20, 32'h0, 1, 4'h0, 10'd21, 32'h0);
    for (int i = 0; i < 12; i++) runCycle();
    applyStimulus(0, 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    runCycle();

    // Read granted right before reset must never return.
    applyStimulus(0, 1, 4'h0, 10'd9, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    runCycle();
    applyStimulus(1, 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    runCycle();
    applyStimulus(0, 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    runCycle();
    applyStimulus(0, 1, 4'h0, 10'd9, 32'h0, 1, 4'h0, 10'd10, 32'h0);
    runCycle();
    runCycle();
    applyStimulus(0, 0, 4'h0, 10'd0, 32'h0, 0, 4'h0, 10'd0, 32'h0);
    runCycle();
    runCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
